// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a registered read port.
module sync_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 16,
    parameter int ALMOST_FULL_LEVEL  = 14,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    localparam int CW                = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  empty_flag,
    output logic                  full_flag,
    output logic                  almost_full_flag,
    output logic                  almost_empty_flag,
    output logic [CW-1:0]         fill_count,
    output logic                  overflow_flag,
    output logic                  underflow_flag,
    input  logic                  clear_errors
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_empty;
    logic w_full;
    logic w_wa;
    logic w_ra;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Flags decode the registered count only; no input reaches them directly.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // Accept decisions are made against the registered full/empty state.
    assign w_wa = write_enable & ~w_full;
    assign w_ra = read_enable & ~w_empty;

    // Storage is never reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wa) r_mem[r_wp] <= write_data;
    end

    // Write and read pointers advance on accepted requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wa) r_wp <= next_ptr(r_wp);
            if (w_ra) r_rp <= next_ptr(r_rp);
        end
    end

    // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wa && !w_ra) begin
            r_count <= r_count + 1'b1;
        end else if (!w_wa && w_ra) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Registered read port; a rejected read keeps the previous word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_ra;
            if (w_ra) r_rdata <= r_mem[r_rp];
        end
    end

    // Sticky error flags; a new error in the same cycle overrides the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (write_enable && w_full) r_ovf <= 1'b1;
            else if (clear_errors)      r_ovf <= 1'b0;
            if (read_enable && w_empty) r_udf <= 1'b1;
            else if (clear_errors)      r_udf <= 1'b0;
        end
    end

    assign read_data         = r_rdata;
    assign read_valid        = r_rvalid;
    assign empty_flag        = w_empty;
    assign full_flag         = w_full;
    assign almost_full_flag  = (r_count >= AF_C);
    assign almost_empty_flag = (r_count <= AE_C);
    assign fill_count        = r_count;
    assign overflow_flag     = r_ovf;
    assign underflow_flag    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with a read-data scoreboard.
module tb_sync_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Instance A: default parameters.
    logic       a_we = 1'b0, a_re = 1'b0, a_clr = 1'b0;
    logic [7:0] a_wd = '0, a_rd;
    logic       a_rv, a_empty, a_full, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_fill;

    // Instance B: depth 5 for the wrap-around test.
    logic       b_we = 1'b0, b_re = 1'b0, b_clr = 1'b0;
    logic [7:0] b_wd = '0, b_rd;
    logic       b_rv, b_empty, b_full, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_fill;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clk = ~clk;

    sync_fifo u_a (
        .clk(clk), .reset(reset), .write_enable(a_we), .write_data(a_wd),
        .read_enable(a_re), .read_data(a_rd), .read_valid(a_rv),
        .empty_flag(a_empty), .full_flag(a_full), .almost_full_flag(a_af),
        .almost_empty_flag(a_ae), .fill_count(a_fill), .overflow_flag(a_ovf),
        .underflow_flag(a_udf), .clear_errors(a_clr)
    );

    sync_fifo #(.FIFO_DEPTH(5), .ALMOST_FULL_LEVEL(4), .ALMOST_EMPTY_LEVEL(1)) u_b (
        .clk(clk), .reset(reset), .write_enable(b_we), .write_data(b_wd),
        .read_enable(b_re), .read_data(b_rd), .read_valid(b_rv),
        .empty_flag(b_empty), .full_flag(b_full), .almost_full_flag(b_af),
        .almost_empty_flag(b_ae), .fill_count(b_fill), .overflow_flag(b_ovf),
        .underflow_flag(b_udf), .clear_errors(b_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus on instance A; requests drop after the edge.
    task automatic cyc_a(input logic we, input logic [7:0] wd, input logic re);
        a_we = we; a_wd = wd; a_re = re;
        @(posedge clk); #1;
        a_we = 1'b0; a_re = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_rd"}, a_rd, 0);
        check({tag, "_rv"}, a_rv, 0);
        check({tag, "_empty"}, a_empty, 1);
        check({tag, "_ae"}, a_ae, 1);
        check({tag, "_full"}, a_full, 0);
        check({tag, "_af"}, a_af, 0);
        check({tag, "_fill"}, a_fill, 0);
        check({tag, "_ovf"}, a_ovf, 0);
        check({tag, "_udf"}, a_udf, 0);
    endtask

    // Scoreboard monitors: every presented read word is matched in order.
    always @(negedge clk) begin
        if (!reset && a_rv) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_unexpected_read: got %0h expected none", a_rd);
            end else begin
                check("a_read_data", a_rd, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_rv) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected_read: got %0h expected none", b_rd);
            end else begin
                check("b_read_data", b_rd, exp_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nr, bc, ph;
        logic dw, dr;

        // Reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_a("rst");

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            cyc_a(1'b1, 8'(i), 1'b0);
            if (i == 0)  check("fill1_empty", a_empty, 0);
            if (i == 1)  check("fill2_ae", a_ae, 1);
            if (i == 2)  check("fill3_ae", a_ae, 0);
            if (i == 12) check("fill13_af", a_af, 0);
            if (i == 13) check("fill14_af", a_af, 1);
        end
        check("full_flag", a_full, 1);
        check("full_fill", a_fill, 16);
        cyc_a(1'b1, 8'hAA, 1'b0);
        check("ovf_set", a_ovf, 1);
        check("ovf_fill", a_fill, 16);

        // Drain and underflow
        for (int i = 0; i < 16; i++) begin
            exp_a.push_back(8'(i));
            cyc_a(1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", a_empty, 1);
        check("drain_fill", a_fill, 0);
        cyc_a(1'b0, 8'h00, 1'b1);
        check("udf_set", a_udf, 1);
        check("udf_rv", a_rv, 0);
        check("udf_rd_hold", a_rd, 8'h0F);
        a_clr = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b0);
        a_clr = 1'b0;
        check("clr_ovf", a_ovf, 0);
        check("clr_udf", a_udf, 0);

        // Set wins over a coincident clear
        a_clr = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b1);
        check("setwins_udf", a_udf, 1);
        cyc_a(1'b0, 8'h00, 1'b0);
        a_clr = 1'b0;
        check("clr2_udf", a_udf, 0);

        // Simultaneous at count 5
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 8'(8'h10 + i), 1'b0);
        exp_a.push_back(8'h10);
        cyc_a(1'b1, 8'h15, 1'b1);
        check("both5_fill", a_fill, 5);
        for (int i = 1; i < 6; i++) begin
            exp_a.push_back(8'(8'h10 + i));
            cyc_a(1'b0, 8'h00, 1'b1);
        end
        check("both5_empty", a_empty, 1);

        // Simultaneous while empty
        cyc_a(1'b1, 8'h55, 1'b1);
        check("bothE_fill", a_fill, 1);
        check("bothE_udf", a_udf, 1);
        check("bothE_rv", a_rv, 0);
        exp_a.push_back(8'h55);
        a_clr = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b1);
        a_clr = 1'b0;
        check("bothE_drain", a_fill, 0);

        // Simultaneous while full
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 8'(8'h80 + i), 1'b0);
        exp_a.push_back(8'h80);
        cyc_a(1'b1, 8'hEE, 1'b1);
        check("bothF_fill", a_fill, 15);
        check("bothF_ovf", a_ovf, 1);
        check("bothF_full", a_full, 0);
        for (int i = 1; i < 16; i++) begin
            exp_a.push_back(8'(8'h80 + i));
            cyc_a(1'b0, 8'h00, 1'b1);
        end
        check("bothF_empty", a_empty, 1);
        a_clr = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b0);
        a_clr = 1'b0;

        // Asynchronous reset mid-transfer at count 9
        for (int i = 0; i < 9; i++) cyc_a(1'b1, 8'(8'h20 + i), 1'b0);
        check("pre_rst_fill", a_fill, 9);
        #2 reset = 1'b1;
        #1 check_reset_a("async");
        @(posedge clk); #1 reset = 1'b0;
        check("post_rst_fill", a_fill, 0);
        cyc_a(1'b1, 8'h3C, 1'b0);
        check("post_rst_w_fill", a_fill, 1);
        exp_a.push_back(8'h3C);
        cyc_a(1'b0, 8'h00, 1'b1);
        check("post_rst_rv", a_rv, 1);
        check("post_rst_rd", a_rd, 8'h3C);
        cyc_a(1'b0, 8'h00, 1'b0);

        // Wrap-around on depth-5 instance: 3 writes / 2 reads per round
        nw = 0; nr = 0; bc = 0;
        for (int s = 0; s < 200 && nr < 24; s++) begin
            ph = s % 5;
            dw = (nw < 24) && (ph < 3) && (bc < 5);
            dr = (bc > 0) && (ph >= 3 || nw >= 24 || bc == 5);
            b_we = dw; b_wd = 8'(8'h40 + nw); b_re = dr;
            if (dr) begin
                exp_b.push_back(8'(8'h40 + nr));
                nr++;
            end
            if (dw) nw++;
            bc = bc + int'(dw) - int'(dr);
            @(posedge clk); #1;
            b_we = 1'b0; b_re = 1'b0;
            check("wrap_fill", b_fill, bc);
            check("wrap_full", b_full, (bc == 5));
            check("wrap_af", b_af, (bc >= 4));
            check("wrap_ae", b_ae, (bc <= 1));
        end
        if (nr != 24) begin
            n_cmp++; n_err++;
            $display("FAIL wrap_budget: got %0d reads expected 24", nr);
        end
        check("wrap_ovf", b_ovf, 0);
        check("wrap_udf", b_udf, 0);

        repeat (2) @(posedge clk);
        #1;
        check("a_pending", exp_a.size(), 0);
        check("b_pending", exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that succeeds the dual-clock `fifo` for paths where producer and consumer share `clk`. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered read port with a valid strobe. It sits between any same-clock producer/consumer pair and is the default buffering element for new single-domain blocks.

## Interface
- `DATA_WIDTH`, 8: width of each stored word.
- `FIFO_DEPTH`, 16: number of entries. Must be ≥ 2; need not be a power of two.
- `ALMOST_FULL_LEVEL`, 14: `almost_full_flag` threshold. Must satisfy `ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL ≤ FIFO_DEPTH`.
- `ALMOST_EMPTY_LEVEL`, 2: `almost_empty_flag` threshold. Must be ≥ 0.
- `CW`, localparam `$clog2(FIFO_DEPTH+1)`: width of `fill_count`.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `write_enable` in 1: write request.
- `write_data` in `DATA_WIDTH`: word to write.
- `read_enable` in 1: read request.
- `read_data` out `DATA_WIDTH`: registered read word.
- `read_valid` out 1: `read_data` was loaded by a read accepted at the previous edge.
- `empty_flag` out 1: `fill_count == 0`.
- `full_flag` out 1: `fill_count == FIFO_DEPTH`.
- `almost_full_flag` out 1: `fill_count ≥ ALMOST_FULL_LEVEL`.
- `almost_empty_flag` out 1: `fill_count ≤ ALMOST_EMPTY_LEVEL`.
- `fill_count` out `CW`: current occupancy.
- `overflow_flag` out 1: sticky; a write was rejected.
- `underflow_flag` out 1: sticky; a read was rejected.
- `clear_errors` in 1: synchronous clear of both sticky flags.

## Operation
- State:
  - storage array of `FIFO_DEPTH` words;
  - write pointer `wp` and read pointer `rp`, each with range 0..`FIFO_DEPTH-1`;
  - registered `fill_count`;
  - `read_data` and `read_valid` registers;
  - two sticky error registers.
- Accept rules use the registered flags only:
  - write accepted: `wa = write_enable & ~full_flag`;
  - read accepted: `ra = read_enable & ~empty_flag`.
- On `wa`:
  - `mem[wp] <= write_data`;
  - `wp` advances; at `FIFO_DEPTH-1` it wraps to 0 (explicit compare, not modulo-2^n).
- On `ra`:
  - `read_data <= mem[rp]`;
  - `rp` advances with the same wrap rule.
- `fill_count <= fill_count + wa - ra`. It never exceeds `FIFO_DEPTH` and never goes below 0.
- Flags:
  - `empty_flag`, `full_flag`, `almost_full_flag` and `almost_empty_flag` are pure decodes of the registered `fill_count`;
  - there is no combinational path from any input to these flags.
- Simultaneous requests:
  - Both requests, 0 < count < `FIFO_DEPTH`: both accepted; count unchanged.
  - Both requests while empty: write accepted, read rejected; count becomes 1; `underflow_flag` set.
  - Both requests while full: read accepted, write rejected; count becomes `FIFO_DEPTH-1`; `overflow_flag` set.
- Sticky error flags:
  - `overflow_flag` sets on `write_enable & full_flag`.
  - `underflow_flag` sets on `read_enable & empty_flag`.
  - Both clear on `clear_errors`. If a set and `clear_errors` coincide, set wins.
- A rejected read leaves `read_data` unchanged.
- Storage contents are not cleared by reset; they are don't-care until written.

## Timing
- Reset asserted: effect is immediate and independent of `clk`.
  - Outputs 0: `read_data`, `read_valid`, `full_flag`, `almost_full_flag`, `fill_count`, `overflow_flag`, `underflow_flag`.
  - Outputs 1: `empty_flag`, and `almost_empty_flag` (because 0 ≤ `ALMOST_EMPTY_LEVEL`).
  - Pointers return to 0.
- Reset mid-transfer: all in-flight data is discarded. The first edge after deassertion behaves as from empty.
- Write latency: a word written at edge N is readable from edge N+1. `empty_flag` falls after edge N.
- Read latency: a read accepted at edge N drives `read_data` and `read_valid = 1` during cycle N→N+1.
  - `read_valid` is 0 in any cycle following an edge with no accepted read.
- Full-rate operation: back-to-back reads and writes sustain one word per cycle in each direction.
- Flag update: every flag reflects `fill_count` after the same edge that updated it.

## Test plan
- **Reset:** apply `reset`, then release. Required: `empty_flag=1`, `almost_empty_flag=1`, `full_flag=0`, `fill_count=0`, `read_valid=0`, `read_data=0`, both error flags 0.
- **Fill to full (defaults):** write 0x00..0x0F on consecutive edges.
  - `almost_full_flag` rises after the 14th write.
  - `full_flag=1` and `fill_count=16` after the 16th write.
  - A 17th write of 0xAA sets `overflow_flag`; count stays 16.
- **Drain and underflow:** from full, read 16 times back-to-back.
  - `read_data` = 0x00..0x0F in order, with `read_valid=1` each cycle.
  - `empty_flag=1` afterwards.
  - One more read: `underflow_flag=1`, `read_valid=0`, `read_data` holds 0x0F.
  - Pulsing `clear_errors` then clears both sticky flags.
- **Simultaneous requests:**
  - At count 5, read+write → count 5, FIFO order preserved.
  - When empty, read+write → count 1, `underflow_flag=1`.
  - When full, read+write → count 15, `overflow_flag=1`.
- **Wrap-around (`FIFO_DEPTH=5`, `ALMOST_FULL_LEVEL=4`, `ALMOST_EMPTY_LEVEL=1`):** interleave 3 writes / 2 reads for 24 words. Required: all 24 words read back in order; `fill_count` never exceeds 5; pointers wrap at 4→0.
- **Asynchronous reset mid-transfer:** at count 9, assert `reset` between clock edges. Required: all outputs reach their reset values before the next edge. After release, a write of 0x3C followed by a read returns 0x3C.
